// File: rtl/interrupt_scheduler_pkg.sv
// Shared definitions for the prioritised interrupt scheduler:
// cause codes, source indices, FSM states and cause-to-source mapping.
package interrupt_scheduler_pkg;

    localparam int NUM_SRC = 8;

    localparam int SRC_TMR  = 0;
    localparam int SRC_BTN0 = 1;
    localparam int SRC_SW0  = 5;

    localparam logic [3:0] CAUSE_TMR  = 4'hD;
    localparam logic [3:0] CAUSE_BTN0 = 4'h4;
    localparam logic [3:0] CAUSE_BTN1 = 4'h5;
    localparam logic [3:0] CAUSE_BTN2 = 4'h6;
    localparam logic [3:0] CAUSE_BTN3 = 4'h7;
    localparam logic [3:0] CAUSE_SW0  = 4'h8;
    localparam logic [3:0] CAUSE_SW1  = 4'h9;
    localparam logic [3:0] CAUSE_SW2  = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // One-hot pending-bit position owned by a given cause code.
    function automatic logic [NUM_SRC-1:0] cause_to_bit(input logic [3:0] cause);
        logic [NUM_SRC-1:0] b;
        b = '0;
        case (cause)
            CAUSE_TMR:  b[SRC_TMR]    = 1'b1;
            CAUSE_BTN0: b[SRC_BTN0]   = 1'b1;
            CAUSE_BTN1: b[SRC_BTN0+1] = 1'b1;
            CAUSE_BTN2: b[SRC_BTN0+2] = 1'b1;
            CAUSE_BTN3: b[SRC_BTN0+3] = 1'b1;
            CAUSE_SW0:  b[SRC_SW0]    = 1'b1;
            CAUSE_SW1:  b[SRC_SW0+1]  = 1'b1;
            CAUSE_SW2:  b[SRC_SW0+2]  = 1'b1;
            default:    b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/interrupt_scheduler_prio.sv
// Fixed-priority encoder: eligible vector -> {any, winning cause}.
// Bit 0 (timer) is highest, then buttons 0..3, then switches 0..2.
module irq_priority_encoder
    import interrupt_scheduler_pkg::*;
(
    input  logic [NUM_SRC-1:0] eligible_i,
    output logic               any_o,
    output logic [3:0]         cause_o
);

    always_comb begin
        any_o   = |eligible_i;
        cause_o = 4'h0;
        priority case (1'b1)
            eligible_i[0]: cause_o = CAUSE_TMR;
            eligible_i[1]: cause_o = CAUSE_BTN0;
            eligible_i[2]: cause_o = CAUSE_BTN1;
            eligible_i[3]: cause_o = CAUSE_BTN2;
            eligible_i[4]: cause_o = CAUSE_BTN3;
            eligible_i[5]: cause_o = CAUSE_SW0;
            eligible_i[6]: cause_o = CAUSE_SW1;
            eligible_i[7]: cause_o = CAUSE_SW2;
            default:       cause_o = 4'h0;
        endcase
    end

endmodule

// File: rtl/interrupt_scheduler.sv
// Edge-captured, masked, prioritised interrupt dispatch to the core
// with a valid/ack request and an mret-terminated service window.
module interrupt_scheduler
    import interrupt_scheduler_pkg::*;
#(
    parameter logic [63:0] VECTOR_BASE  = 64'h100,
    parameter int          VECTOR_SHIFT = 4
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        global_ie_in,
    input  logic        csr_mtie_in,
    input  logic        csr_meie_in,
    input  logic [3:0]  csr_mbutton_ctrl_in,
    input  logic [2:0]  csr_mswitch_ctrl_in,
    input  logic        timer_trigger_in,
    input  logic [3:0]  external_button,
    input  logic [2:0]  external_switch,
    input  logic        irq_ack_in,
    input  logic        irq_done_in,
    output logic        irq_valid_out,
    output logic [3:0]  irq_cause_out,
    output logic [63:0] irq_pc_out,
    output logic        in_service_out,
    output logic [7:0]  pending_out,
    output logic        lost_irq_out
);

    irq_state_e         state_q;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [3:0]         cause_q;
    logic [63:0]        pc_q;
    logic               valid_q;
    logic               in_service_q;
    logic               lost_q, lost_d;

    logic [NUM_SRC-1:0] raw;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] capture;
    logic [NUM_SRC-1:0] clear;
    logic [NUM_SRC-1:0] eligible;
    logic               win_any;
    logic [3:0]         win_cause;
    logic [63:0]        win_pc;
    logic               take_ack;

    assign raw    = {external_switch, external_button, timer_trigger_in};
    assign enable = {csr_mswitch_ctrl_in & {3{csr_meie_in}},
                     csr_mbutton_ctrl_in & {4{csr_meie_in}},
                     csr_mtie_in};

    assign rise     = raw & ~prev_q;
    assign capture  = rise & enable;
    assign eligible = pending_q & enable;
    assign take_ack = (state_q == ST_REQ) && irq_ack_in;
    assign clear    = take_ack ? cause_to_bit(cause_q) : '0;

    // A new edge landing on the bit being acked wins and is not "lost".
    always_comb begin
        pending_d = (pending_q & ~clear) | capture;
        lost_d    = |(capture & pending_q & ~clear);
    end

    irq_priority_encoder u_prio (
        .eligible_i (eligible),
        .any_o      (win_any),
        .cause_o    (win_cause)
    );

    assign win_pc = VECTOR_BASE + (64'(win_cause) << VECTOR_SHIFT);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            prev_q    <= '0;
            pending_q <= '0;
            lost_q    <= 1'b0;
        end else begin
            prev_q    <= raw;
            pending_q <= pending_d;
            lost_q    <= lost_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= ST_IDLE;
            cause_q      <= 4'h0;
            pc_q         <= 64'h0;
            valid_q      <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (global_ie_in && win_any) begin
                        state_q <= ST_REQ;
                        cause_q <= win_cause;
                        pc_q    <= win_pc;
                        valid_q <= 1'b1;
                    end
                end
                // Request is held until ack regardless of MIE or mask changes.
                ST_REQ: begin
                    if (irq_ack_in) begin
                        state_q      <= ST_SERVICE;
                        valid_q      <= 1'b0;
                        in_service_q <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (irq_done_in) begin
                        state_q      <= ST_IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    valid_q      <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_valid_out  = valid_q;
    assign irq_cause_out  = cause_q;
    assign irq_pc_out     = pc_q;
    assign in_service_out = in_service_q;
    assign pending_out    = pending_q;
    assign lost_irq_out   = lost_q;

endmodule
